rock_level_ctrl: RTL and testbench
==================================

ROCK_LEVEL_CTRL -- requirements
Module: rock_level_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 25000000; clock cycles per ramp/quiet step.
REQ-002 Parameter QUIET_STEPS, default 30; consecutive cry-free steps in HOLD before ramp-down starts.
REQ-003 Parameter MAX_LEVEL, default 7; highest target level, within 1..7.
REQ-004 CLK  in  1  system clock; all logic on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 CryDet  in  1  asynchronous cry-detector level; high = baby crying.
REQ-007 StartBtn  in  1  asynchronous start/stop push-button; high = pressed.
REQ-008 UpBtn  in  1  asynchronous button that raises the target level.
REQ-009 DownBtn  in  1  asynchronous button that lowers the target level.
REQ-010 Freq  out  3  registered frequency level 0..7 for the PWM output stage.
REQ-011 Amp  out  3  registered amplitude level 0..7 for the PWM output stage.
REQ-012 Active  out  1  high when state is not IDLE.
REQ-013 State  out  2  FSM state: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.

Function
REQ-014 Each async input SHALL pass through a 2-flop synchronizer.
REQ-015 Each button SHALL produce a one-cycle pulse on the synchronized rising edge; a pulse appears 3 cycles after the pin rises.
REQ-016 Step counter SHALL count 0..STEP_CYCLES-1 and wrap while state is not IDLE; step_tick SHALL pulse at the terminal count; the counter SHALL be held at 0 in IDLE.
REQ-017 Target tgt SHALL reset to 4; an Up pulse increments it, saturating at MAX_LEVEL; a Down pulse decrements it, saturating at 1; simultaneous Up and Down pulses leave it unchanged; all of this applies in every state.
REQ-018 Current level lvl (0..7) SHALL change by at most 1 per step_tick; Freq and Amp SHALL both equal lvl, registered.
REQ-019 IDLE: lvl=0; a Start pulse or synchronized CryDet high SHALL move to RAMP_UP on the next cycle; both together SHALL cause a single transition.
REQ-020 RAMP_UP: on step_tick, lvl moves one toward tgt; when lvl equals tgt after the update, go to HOLD.
REQ-021 RAMP_UP/HOLD: a Start pulse SHALL go to RAMP_DOWN.
REQ-022 HOLD: on step_tick, lvl tracks tgt by one; the quiet counter increments on step_tick while CryDet is low and clears whenever synchronized CryDet is high; on the step_tick where the counter reaches QUIET_STEPS, go to RAMP_DOWN.
REQ-023 RAMP_DOWN: on step_tick, lvl decrements; lvl reaching 0 SHALL go to IDLE; CryDet high or a Start pulse SHALL return to RAMP_UP, keeping the current lvl.
REQ-024 A Start pulse SHALL take priority over CryDet in RAMP_UP and HOLD.
REQ-025 The quiet counter SHALL clear on every entry to HOLD.
REQ-026 The step counter SHALL NOT reset on state changes, except on entry to IDLE.

Reset
REQ-027 Reset SHALL force: state=IDLE, lvl=0, Freq=0, Amp=0, Active=0, State=0, tgt=4, step and quiet counters=0, synchronizers and edge flops=0.
REQ-028 Reset asserted mid-ramp SHALL take effect immediately and asynchronously; release SHALL NOT generate button pulses.

Structure
REQ-029 Package rock_pkg SHALL hold: state enum, LEVEL_W=3, default MAX_LEVEL and default tgt=4.
REQ-030 Sub-module btn_sync_edge SHALL contain the 2-flop synchronizer plus rising-edge detect; it is instantiated three times, and CryDet uses only its synchronized level.
REQ-031 Freq/Amp SHALL connect directly to the Freq/Amp inputs of the PWM output stage.

Verification (STEP_CYCLES=4, QUIET_STEPS=3)
REQ-032 Reset then Start press -> State=1 at cycle 4; lvl 1,2,3,4 on successive step_ticks; State=2 when lvl=4.
REQ-033 In HOLD, CryDet low for 3 steps -> State=3; lvl 3,2,1,0; then State=0, Active=0.
REQ-034 In RAMP_DOWN at lvl=2, CryDet high -> State=1; lvl climbs 3,4; HOLD.
REQ-035 Up pressed 5 times from tgt=4 -> tgt=7 (saturates); in HOLD lvl reaches 7; Down and Up in the same cycle -> tgt unchanged.
REQ-036 Start and CryDet rise in the same cycle in IDLE -> one transition to RAMP_UP; Reset at lvl=3 -> all outputs 0 immediately.

Source files
------------

// File: rtl/rock_pkg.sv
// rtl/rock_pkg.sv - shared types, widths and level helper for the rocker level controller
package rock_pkg;

   localparam int LEVEL_W       = 3;
   localparam int DEF_MAX_LEVEL = 7;
   localparam logic [LEVEL_W-1:0] DEF_TGT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_t;

   function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                      input logic [LEVEL_W-1:0] goal);
      if (cur < goal)
         return cur + LEVEL_W'(1);
      else if (cur > goal)
         return cur - LEVEL_W'(1);
      else
         return cur;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - 2-flop synchronizer with registered rising-edge pulse
module btn_sync_edge #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
         rise <= '0;
      end else begin
         meta <= pin;
         sync <= meta;
         prev <= sync;
         rise <= sync & ~prev;
      end
   end

   // Level is taken from the edge flop so it lines up in time with the rise pulse.
   assign level = prev;

endmodule

// File: rtl/rock_level_ctrl.sv
// rtl/rock_level_ctrl.sv - cry-driven rocker level controller: target/level ramping FSM
module rock_level_ctrl
   import rock_pkg::*;
#(
   parameter int STEP_CYCLES = 25000000,
   parameter int QUIET_STEPS = 30,
   parameter int MAX_LEVEL   = DEF_MAX_LEVEL
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               CryDet,
   input  logic               StartBtn,
   input  logic               UpBtn,
   input  logic               DownBtn,
   output logic [LEVEL_W-1:0] Freq,
   output logic [LEVEL_W-1:0] Amp,
   output logic               Active,
   output logic [1:0]         State
);

   localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int QW    = (QUIET_STEPS > 1) ? $clog2(QUIET_STEPS + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [QW-1:0]      QUIET_LAST = QW'(QUIET_STEPS - 1);
   localparam logic [LEVEL_W-1:0] TGT_MAX    = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] TGT_MIN    = LEVEL_W'(1);

   logic [1:0] sc_level, sc_rise;
   logic       up_level, up_rise, down_level, down_rise;
   logic       start_p, cry;
   logic       unused_sync;

   // Start and CryDet share one instance so the cry level and start pulse stay aligned.
   btn_sync_edge #(.WIDTH(2)) u_sync_start_cry (
      .clk(CLK), .rst(Reset), .pin({CryDet, StartBtn}), .level(sc_level), .rise(sc_rise)
   );
   btn_sync_edge #(.WIDTH(1)) u_sync_up (
      .clk(CLK), .rst(Reset), .pin(UpBtn), .level(up_level), .rise(up_rise)
   );
   btn_sync_edge #(.WIDTH(1)) u_sync_down (
      .clk(CLK), .rst(Reset), .pin(DownBtn), .level(down_level), .rise(down_rise)
   );

   assign start_p     = sc_rise[0];
   assign cry         = sc_level[1];
   assign unused_sync = ^{sc_level[0], sc_rise[1], up_level, down_level};

   state_t             state, state_next;
   logic [LEVEL_W-1:0] lvl, lvl_next, tgt;
   logic [QW-1:0]      quiet, quiet_next;
   logic [CNT_W-1:0]   cnt;
   logic               step_tick;

   assign step_tick = (state != ST_IDLE) && (cnt == CNT_LAST);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         cnt <= '0;
      else if (state == ST_IDLE || step_tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         tgt <= DEF_TGT;
      else if (up_rise && !down_rise && tgt < TGT_MAX)
         tgt <= tgt + LEVEL_W'(1);
      else if (down_rise && !up_rise && tgt > TGT_MIN)
         tgt <= tgt - LEVEL_W'(1);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
         lvl   <= '0;
         quiet <= '0;
      end else begin
         state <= state_next;
         lvl   <= lvl_next;
         quiet <= quiet_next;
      end
   end

   // quiet_next defaults to 0 so every entry into HOLD starts a fresh quiet count.
   always_comb begin
      state_next = state;
      lvl_next   = lvl;
      quiet_next = '0;
      case (state)
         ST_IDLE: begin
            lvl_next = '0;
            if (start_p || cry)
               state_next = ST_RAMP_UP;
         end
         ST_RAMP_UP: begin
            if (start_p)
               state_next = ST_RAMP_DOWN;
            else if (step_tick) begin
               lvl_next = step_toward(lvl, tgt);
               if (lvl_next == tgt)
                  state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            quiet_next = quiet;
            if (start_p)
               state_next = ST_RAMP_DOWN;
            else begin
               if (step_tick)
                  lvl_next = step_toward(lvl, tgt);
               if (cry)
                  quiet_next = '0;
               else if (step_tick) begin
                  if (quiet == QUIET_LAST)
                     state_next = ST_RAMP_DOWN;
                  else
                     quiet_next = quiet + QW'(1);
               end
            end
         end
         ST_RAMP_DOWN: begin
            if (start_p || cry)
               state_next = ST_RAMP_UP;
            else if (step_tick) begin
               if (lvl <= LEVEL_W'(1)) begin
                  lvl_next   = '0;
                  state_next = ST_IDLE;
               end else
                  lvl_next = lvl - LEVEL_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign Freq   = lvl;
   assign Amp    = lvl;
   assign Active = (state != ST_IDLE);
   assign State  = state;

endmodule

// File: tb/tb_rock_level_ctrl.sv
// tb/tb_rock_level_ctrl.sv - directed table, corner sequences and random run against a level model
module tb_rock_level_ctrl;

   localparam int STEP  = 4;
   localparam int QUIET = 3;
   localparam int MAXL  = 7;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       CryDet = 1'b0, StartBtn = 1'b0, UpBtn = 1'b0, DownBtn = 1'b0;
   logic [2:0] Freq, Amp;
   logic       Active;
   logic [1:0] State;

   int n_chk = 0;
   int n_fail = 0;

   rock_level_ctrl #(.STEP_CYCLES(STEP), .QUIET_STEPS(QUIET), .MAX_LEVEL(MAXL)) dut (
      .CLK(CLK), .Reset(Reset), .CryDet(CryDet), .StartBtn(StartBtn),
      .UpBtn(UpBtn), .DownBtn(DownBtn), .Freq(Freq), .Amp(Amp),
      .Active(Active), .State(State)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference model: pins reach the controller three edges after they are sampled.
   int         m_state, m_lvl, m_tgt, m_step, m_quiet;
   logic [4:0] h_st, h_cry, h_up, h_dn;

   function automatic int toward(input int c, input int g);
      return c + int'(g > c) - int'(g < c);
   endfunction

   task automatic model_reset();
      m_state = 0; m_lvl = 0; m_tgt = 4; m_step = 0; m_quiet = 0;
      h_st = '0; h_cry = '0; h_up = '0; h_dn = '0;
   endtask

   task automatic model_step();
      logic sp, cr, up, dn, tick;
      int   ns, nl, nq;
      h_st  = {h_st[3:0], StartBtn};
      h_cry = {h_cry[3:0], CryDet};
      h_up  = {h_up[3:0], UpBtn};
      h_dn  = {h_dn[3:0], DownBtn};
      sp = h_st[3] & ~h_st[4];
      cr = h_cry[3];
      up = h_up[3] & ~h_up[4];
      dn = h_dn[3] & ~h_dn[4];
      tick = (m_state != 0) && (m_step == STEP - 1);
      ns = m_state; nl = m_lvl; nq = 0;
      case (m_state)
         0: if (sp || cr) ns = 1;
         1: if (sp) ns = 3;
            else if (tick) begin
               nl = toward(m_lvl, m_tgt);
               if (nl == m_tgt) ns = 2;
            end
         2: begin
            nq = m_quiet;
            if (sp) ns = 3;
            else begin
               if (tick) nl = toward(m_lvl, m_tgt);
               if (cr) nq = 0;
               else if (tick) begin
                  nq = nq + 1;
                  if (nq == QUIET) ns = 3;
               end
            end
         end
         default: if (sp || cr) ns = 1;
            else if (tick) begin
               nl = (m_lvl > 0) ? m_lvl - 1 : 0;
               if (nl == 0) ns = 0;
            end
      endcase
      m_step = (m_state == 0) ? 0 : (m_step + 1) % STEP;
      if (up && !dn) m_tgt = (m_tgt + 1 > MAXL) ? MAXL : m_tgt + 1;
      else if (dn && !up) m_tgt = (m_tgt - 1 < 1) ? 1 : m_tgt - 1;
      m_state = ns; m_lvl = nl; m_quiet = nq;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input logic u, input logic d);
      UpBtn = u; DownBtn = d;
      ticks(2);
      UpBtn = 1'b0; DownBtn = 1'b0;
      ticks(2);
   endtask

   task automatic release_reset();
      StartBtn = 0; CryDet = 0; UpBtn = 0; DownBtn = 0;
      Reset = 1'b1;
      model_reset();
      repeat (2) @(negedge CLK);
      Reset = 1'b0;
   endtask

   typedef struct {
      logic       start, cry, up, down;
      int         ncyc;
      logic [1:0] st;
      logic [2:0] lv;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  2'd0, 3'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd1, 3'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  2'd1, 3'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  2'd1, 3'd2};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  2'd1, 3'd3};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  2'd2, 3'd4};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 11, 2'd2, 3'd4};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd3, 3'd4};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  2'd3, 3'd3};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,  2'd3, 3'd2};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4,  2'd1, 3'd2};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4,  2'd1, 3'd3};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4,  2'd2, 3'd4};

      model_reset();
      #12;
      check("reset_state", State, 2'd0);
      check("reset_freq", Freq, 3'd0);
      check("reset_amp", Amp, 3'd0);
      check("reset_active", Active, 1'b0);
      @(negedge CLK);
      Reset = 1'b0;

      // Start press, ramp to target, quiet ramp-down, cry re-ramp from level 2.
      for (int i = 0; i < 13; i++) begin
         StartBtn = tbl[i].start; CryDet = tbl[i].cry;
         UpBtn = tbl[i].up; DownBtn = tbl[i].down;
         ticks(tbl[i].ncyc);
         check($sformatf("vec%0d_state", i), State, tbl[i].st);
         check($sformatf("vec%0d_level", i), Freq, tbl[i].lv);
      end

      // Cry stays high so HOLD persists while the target is adjusted.
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
      ticks(20);
      check("up_sat_state", State, 2'd2);
      check("up_sat_freq", Freq, 3'd7);
      check("up_sat_amp", Amp, 3'd7);
      press(1'b0, 1'b1);
      ticks(20);
      check("down_one_level", Freq, 3'd6);
      press(1'b1, 1'b1);
      ticks(20);
      check("up_down_same_cycle", Freq, 3'd6);
      check("up_down_state", State, 2'd2);

      // Start and cry rising together from IDLE, then async reset mid-ramp.
      release_reset();
      StartBtn = 1'b1; CryDet = 1'b1;
      ticks(3);
      check("both_edge3_state", State, 2'd0);
      StartBtn = 1'b0;
      tick();
      check("both_edge4_state", State, 2'd1);
      ticks(3);
      check("both_single_transition", State, 2'd1);
      ticks(9);
      check("ramp_before_reset", Freq, 3'd3);
      #2 Reset = 1'b1;
      #1;
      check("async_reset_freq", Freq, 3'd0);
      check("async_reset_amp", Amp, 3'd0);
      check("async_reset_state", State, 2'd0);
      check("async_reset_active", Active, 1'b0);

      // Random pin activity against the model.
      @(negedge CLK);
      release_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) StartBtn = ~StartBtn;
         if ($urandom_range(0, 59) == 0) CryDet = ~CryDet;
         if ($urandom_range(0, 11) == 0) UpBtn = ~UpBtn;
         if ($urandom_range(0, 11) == 0) DownBtn = ~DownBtn;
         tick();
         check($sformatf("rand_cycle_%0d", i), {State, Freq, Amp, Active},
               {2'(m_state), 3'(m_lvl), 3'(m_lvl), (m_state != 0)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
